vram_arbiter: RTL and testbench

Single-port video SRAM arbiter and access sequencer between the VGA capture write stream and the JAMMA-side display read port. Accepts one-byte capture writes (`wrVga`/`aVga`/`dVga`), commits them to SRAM and returns the `wrVgaReq` completion pulse that advances the capture column counter. Services a level-held read request from the display scanner and guards it against write starvation. Drives active-high internal SRAM strobes; pad polarity inversion lives in the top level.

---
 rtl/vram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: serialises capture writes and display reads onto one SRAM port.
// Define VRAM_WRBUF_EN for a 4-entry capture write FIFO; otherwise one holding register.
module vram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_MAX    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrVga,
  input  logic [ADDR_W-1:0] aVga,
  input  logic [DATA_W-1:0] dVga,
  output logic              wrVgaReq,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData,
  output logic              rdAck,
  input  logic              ovfClr,
  output logic              ovf,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [DATA_W-1:0] sramDout,
  input  logic [DATA_W-1:0] sramDin,
  output logic              sramCe,
  output logic              sramWe,
  output logic              sramOe
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [3:0] LAST_CNT   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              last_c, rd_eff;
  logic              buf_push, buf_pop, buf_full, buf_empty, drop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic              wrVgaReq_q, rdAck_q, ovf_q;
  logic              sramCe_q, sramWe_q, sramOe_q;
  logic [DATA_W-1:0] rdData_q, sramDout_q;
  logic [ADDR_W-1:0] sramAddr_q;

  assign last_c   = (cnt_q == LAST_CNT);
  assign rd_eff   = rdReq && !rdAck_q;
  // Head leaves the buffer at the end of the last WRITE cycle, so the
  // wrVgaReq cycle already sees a free slot and the next head.
  assign buf_pop  = (state_q == WRITE) && last_c;
  assign buf_push = wrVga && !buf_full;
  assign drop     = wrVga && buf_full;

`ifdef VRAM_WRBUF_EN
  localparam int unsigned DEPTH = 4;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [1:0]        wptr_q, rptr_q;
  logic [2:0]        count_q;

  assign buf_full  = (count_q == 3'(DEPTH));
  assign buf_empty = (count_q == '0);
  assign head_addr = fifo_addr_q[rptr_q];
  assign head_data = fifo_data_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (buf_push) begin
        fifo_addr_q[wptr_q] <= aVga;
        fifo_data_q[wptr_q] <= dVga;
        wptr_q              <= wptr_q + 2'd1;
      end
      if (buf_pop) rptr_q <= rptr_q + 2'd1;
      count_q <= count_q + 3'(buf_push) - 3'(buf_pop);
    end
  end
`else
  logic              valid_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;

  assign buf_full  = valid_q;
  assign buf_empty = !valid_q;
  assign head_addr = hold_addr_q;
  assign head_data = hold_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      if (buf_pop) valid_q <= 1'b0;
      if (buf_push) begin
        valid_q     <= 1'b1;
        hold_addr_q <= aVga;
        hold_data_q <= dVga;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rd_eff && (starve_q == STARVE_LIM)) state_d = READ;
        else if (!buf_empty)                    state_d = WRITE;
        else if (rd_eff)                        state_d = READ;
      end
      WRITE, READ: begin
        if (last_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rd_eff || ((state_q == IDLE) && (state_d == READ)))
      starve_d = '0;
    else if ((state_q == IDLE) && (state_d == WRITE) && (starve_q != '1))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      wrVgaReq_q <= 1'b0;
      rdAck_q    <= 1'b0;
      rdData_q   <= '0;
      ovf_q      <= 1'b0;
      sramAddr_q <= '0;
      sramDout_q <= '0;
      sramCe_q   <= 1'b0;
      sramWe_q   <= 1'b0;
      sramOe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      // Strobes are registered from next state; WE drops on the last cycle.
      sramCe_q   <= (state_d != IDLE);
      sramWe_q   <= (state_d == WRITE) && (cnt_d != LAST_CNT);
      sramOe_q   <= (state_d == READ);
      if (state_d == WRITE) begin
        sramAddr_q <= head_addr;
        sramDout_q <= head_data;
      end else if (state_d == READ) begin
        sramAddr_q <= rdAddr;
      end
      wrVgaReq_q <= buf_pop;
      rdAck_q    <= (state_q == READ) && last_c;
      if ((state_q == READ) && last_c) rdData_q <= sramDin;
      if (drop)        ovf_q <= 1'b1;
      else if (ovfClr) ovf_q <= 1'b0;
    end
  end

  assign wrVgaReq = wrVgaReq_q;
  assign rdAck    = rdAck_q;
  assign rdData   = rdData_q;
  assign ovf      = ovf_q;
  assign sramAddr = sramAddr_q;
  assign sramDout = sramDout_q;
  assign sramCe   = sramCe_q;
  assign sramWe   = sramWe_q;
  assign sramOe   = sramOe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed and random traffic against a time-based reference model.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW = 16, DW = 8, AC = 2, SMAX = 2;
`ifdef VRAM_WRBUF_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrVga = 1'b0, rdReq = 1'b0, ovfClr = 1'b0;
  logic [AW-1:0] aVga = '0, rdAddr = '0;
  logic [DW-1:0] dVga = '0;
  logic          wrVgaReq, rdAck, ovf, sramCe, sramWe, sramOe;
  logic [DW-1:0] rdData, sramDout, sramDin;
  logic [AW-1:0] sramAddr;

  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .wrVga(wrVga), .aVga(aVga), .dVga(dVga), .wrVgaReq(wrVgaReq),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdData(rdData), .rdAck(rdAck), .ovfClr(ovfClr),
    .ovf(ovf), .sramAddr(sramAddr), .sramDout(sramDout), .sramDin(sramDin),
    .sramCe(sramCe), .sramWe(sramWe), .sramOe(sramOe));

  // SRAM content is a fixed function of address (0x8000 reads 0x3C)
  function automatic logic [7:0] sram_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hBC;
  endfunction
  assign sramDin = sram_f(sramAddr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration decisions placed on a cycle timeline
  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];
  int  inflight_free = -1, next_dec = 0, rdack_cyc = -1, starve = 0, rst_at = -10;
  bit  ovf_m = 1'b0, mon_on = 1'b0;
  bit          e_ce[int], e_we[int], e_oe[int], e_wr[int];
  logic [15:0] e_addr[int];
  logic [7:0]  e_dout[int];
  int          q_wreq[$];
  int          q_rack_t[$];
  logic [7:0]  q_rack_d[$];

  task automatic sched(input int t0, input bit w, input logic [15:0] a, input logic [7:0] d);
    for (int i = 0; i < AC; i++) begin
      e_ce[t0+i] = 1'b1;  e_we[t0+i] = w && (i < AC-1); e_oe[t0+i] = !w;
      e_wr[t0+i] = w;     e_addr[t0+i] = a;              e_dout[t0+i] = d;
    end
  endtask

  task automatic prune(input int c);
    int keys[$];
    foreach (e_ce[k]) if (k > c) keys.push_back(k);
    foreach (keys[i]) begin
      e_ce.delete(keys[i]); e_we.delete(keys[i]); e_oe.delete(keys[i]);
      e_wr.delete(keys[i]); e_addr.delete(keys[i]); e_dout.delete(keys[i]);
    end
    while (q_wreq.size() > 0 && q_wreq[$] > c) void'(q_wreq.pop_back());
    while (q_rack_t.size() > 0 && q_rack_t[$] > c) begin
      void'(q_rack_t.pop_back()); void'(q_rack_d.pop_back());
    end
  endtask

  task automatic model_step();
    int  c = cyc;
    int  occ;
    bit  rd_eff, drop, gw, gr;
    wr_t e;
    if (rst) begin
      wq.delete(); inflight_free = -1; rdack_cyc = -1; starve = 0; ovf_m = 1'b0;
      next_dec = c + 1; rst_at = c; prune(c); mon_on = 1'b1;
      return;
    end
    rd_eff = rdReq && (rdack_cyc != c);
    occ  = wq.size() + ((inflight_free > c) ? 1 : 0);
    drop = wrVga && (occ >= DEPTH);
    gw = 1'b0; gr = 1'b0;
    if (c == next_dec) begin
      if (rd_eff && starve == SMAX) gr = 1'b1;
      else if (wq.size() > 0)       gw = 1'b1;
      else if (rd_eff)              gr = 1'b1;
      if (gw) begin
        e = wq.pop_front();
        sched(c+1, 1'b1, e.a, e.d);
        q_wreq.push_back(c+AC+1);
        inflight_free = c+AC+1;
      end
      if (gr) begin
        sched(c+1, 1'b0, rdAddr, 8'h00);
        q_rack_t.push_back(c+AC+1);
        q_rack_d.push_back(sram_f(rdAddr));
        rdack_cyc = c+AC+1;
      end
      next_dec = (gw || gr) ? c+AC+1 : c+1;
    end
    if (!rd_eff || gr)           starve = 0;
    else if (gw && starve < 15)  starve++;
    if (wrVga && !drop) wq.push_back(wr_t'({aVga, dVga}));
    if (drop)        ovf_m = 1'b1;
    else if (ovfClr) ovf_m = 1'b0;
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT responds
  always @(negedge clk) begin : monitor
    int   c, t;
    bit   ece;
    logic [7:0] d;
    c = cyc;
    if (mon_on) begin
      ece = e_ce.exists(c) ? e_ce[c] : 1'b0;
      chk("sramCe", sramCe, ece);
      chk("sramWe", sramWe, ece ? e_we[c] : 1'b0);
      chk("sramOe", sramOe, ece ? e_oe[c] : 1'b0);
      if (ece) begin
        chk("sramAddr", sramAddr, e_addr[c]);
        if (e_wr[c]) chk("sramDout", sramDout, e_dout[c]);
      end
      if (wrVgaReq) begin
        if (q_wreq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wrVgaReq @cycle %0d: got pulse, expected none", c);
        end else chk("wrVgaReq_cycle", c, q_wreq.pop_front());
      end
      while (q_wreq.size() > 0 && q_wreq[0] < c) begin
        t = q_wreq.pop_front(); n_chk++; n_fail++;
        $display("FAIL wrVgaReq_missing: got no pulse, expected at cycle %0d", t);
      end
      if (rdAck) begin
        if (q_rack_t.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rdAck @cycle %0d: got pulse, expected none", c);
        end else begin
          t = q_rack_t.pop_front(); d = q_rack_d.pop_front();
          chk("rdAck_cycle", c, t);
          chk("rdData", rdData, d);
        end
      end
      while (q_rack_t.size() > 0 && q_rack_t[0] < c) begin
        t = q_rack_t.pop_front(); void'(q_rack_d.pop_front()); n_chk++; n_fail++;
        $display("FAIL rdAck_missing: got no pulse, expected at cycle %0d", t);
      end
      chk("ovf", ovf, ovf_m);
      if (rst_at == c-1) begin
        chk("rst_rdData", rdData, 8'h00);
        chk("rst_sramAddr", sramAddr, 16'h0000);
        chk("rst_sramDout", sramDout, 8'h00);
        chk("rst_wrVgaReq", wrVgaReq, 1'b0);
        chk("rst_rdAck", rdAck, 1'b0);
      end
    end
  end

  // Display-side requester holds rdReq until it sees rdAck
  bit          rd_active = 1'b0;
  logic [15:0] rd_a = '0;

  task automatic drive(input bit w, input logic [15:0] a, input logic [7:0] d,
                       input bit rs, input logic [15:0] ra, input bit clr, input bit r);
    @(negedge clk); #1;
    if (rdAck) rd_active = 1'b0;
    if (rs && !rd_active) begin rd_active = 1'b1; rd_a = ra; end
    wrVga = w; aVga = a; dVga = d; rdReq = rd_active; rdAddr = rd_a; ovfClr = clr; rst = r;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);
    // single write, then single read
    drive(1'b1, 16'h0123, 8'hA5, 1'b0, '0, 1'b0, 1'b0);
    idle(6);
    drive(1'b0, '0, '0, 1'b1, 16'h8000, 1'b0, 1'b0);
    idle(6);
    // write and read contending in the same arbitration cycle
    drive(1'b1, 16'h1111, 8'h11, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 16'h2222, 1'b0, 1'b0);
    idle(10);
    // back-to-back writes with a held read: starvation limit / overflow
    drive(1'b1, 16'hA000, 8'hC0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 16'hA001, 8'hC1, 1'b1, 16'h4444, 1'b0, 1'b0);
    drive(1'b1, 16'hA002, 8'hC2, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 16'hA003, 8'hC3, 1'b0, '0, 1'b0, 1'b0);
    idle(22);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    // writes two cycles apart overflow a single slot; clear, then hit the free cycle exactly
    drive(1'b1, 16'hB000, 8'h5A, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 16'hB001, 8'h5B, 1'b0, '0, 1'b0, 1'b0);
    idle(8);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 16'hB100, 8'h66, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 16'hB101, 8'h77, 1'b0, '0, 1'b0, 1'b0);
    idle(8);
    // reset during the first WRITE cycle with a read held through reset
    drive(1'b1, 16'hC000, 8'h99, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 16'h5555, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(12);
    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) == 0, 16'($urandom), 8'($urandom),
            $urandom_range(0, 5) == 0, 16'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0);
    idle(30);
    @(negedge clk); #2;
    n_chk++;
    if (q_wreq.size() != 0) begin
      n_fail++; $display("FAIL wrVgaReq_leftover: got %0d unseen pulses, expected 0", q_wreq.size());
    end
    n_chk++;
    if (q_rack_t.size() != 0) begin
      n_fail++; $display("FAIL rdAck_leftover: got %0d unseen pulses, expected 0", q_rack_t.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
